wb_regfile: RTL and testbench
=============================

// Module: wb_regfile
// PURPOSE
//   Integer register file at the write-back end of the miniRV datapath. Consumes the selected
//   write-back value (PC+4 / ALU result / load data / immediate) and the destination index,
//   commits it on the clock edge, and serves two combinational read ports to decode.
//   Also registers a one-cycle-delayed commit record (debug_wb_*) for the trace comparator
//   and keeps a retired-write counter.
// PARAMETERS
//   DATA_W   32   register / write-data width
//   ADDR_W   5    register index width (2**ADDR_W registers, x0 hardwired to zero)
// PORTS
//   cpu_clk          in   1       clock, all state updates on rising edge
//   cpu_rst_n        in   1       synchronous active-low reset
//   rf_we            in   1       write enable from control unit
//   rf_wR            in   ADDR_W  destination register index
//   rf_wD            in   DATA_W  write-back data (output of write-data select)
//   wb_pc            in   DATA_W  PC of the instruction writing back
//   wb_valid         in   1       an instruction retires this cycle
//   rf_rR1, rf_rR2   in   ADDR_W  read indices
//   rf_rD1, rf_rD2   out  DATA_W  read data (combinational)
//   debug_wb_have_inst out 1      registered: instruction retired last cycle
//   debug_wb_pc      out  DATA_W  registered: PC of that instruction
//   debug_wb_ena     out  1       registered: that instruction wrote a register (x0 excluded)
//   debug_wb_reg     out  ADDR_W  registered: index written
//   debug_wb_value   out  DATA_W  registered: value written
//   wr_count         out  32      number of committed register writes since reset
// BEHAVIOUR
//   - Reset (cpu_rst_n==0 at rising edge): all registers x1..x31 <= 0, all debug_* <= 0,
//     wr_count <= 0. Writes presented in a reset cycle are discarded, not deferred.
//   - Commit: at rising edge, if cpu_rst_n && rf_we && rf_wR!=0 && wb_valid: reg[rf_wR] <= rf_wD.
//     rf_we without wb_valid is ignored (bubble). Writes to x0 never change state.
//   - Read: rf_rDn = 0 if rf_rRn==0; else if commit condition true this cycle and rf_rRn==rf_wR,
//     rf_rDn = rf_wD (write-through bypass); else reg[rf_rRn]. Both ports independent;
//     both may address the same register or the write target simultaneously.
//   - Debug record, latency 1: at each non-reset edge, debug_wb_have_inst <= wb_valid;
//     debug_wb_pc <= wb_pc; debug_wb_ena <= wb_valid && rf_we && rf_wR!=0;
//     debug_wb_reg <= rf_wR; debug_wb_value <= rf_wD. When debug_wb_ena==0, reg/value
//     still reflect the sampled inputs (trace ignores them).
//   - wr_count increments by 1 on every commit (same condition as register write);
//     wraps 0xFFFF_FFFF -> 0 with no flag.
//   - Reset asserted mid-run: state cleared at that edge; read ports return 0 for all
//     indices the following cycle unless bypassed by a commit in that cycle.
// TESTING
//   1. Reset held 2 cycles, then read all 32 indices -> every rf_rD = 0, wr_count = 0, debug_* = 0.
//   2. Write x5 = 0xDEAD_BEEF (we=1,valid=1) -> same cycle rf_rD1(rR1=5)=0xDEAD_BEEF via bypass;
//      next cycle read=0xDEAD_BEEF, debug_wb_ena=1, reg=5, value=0xDEAD_BEEF, wr_count=1.
//   3. Write x0 = 0x1234 -> rf_rD(rR=0)=0 same and next cycle; debug_wb_ena=0,
//      debug_wb_have_inst=1; wr_count unchanged.
//   4. rf_we=1, wb_valid=0, wR=7, wD=0x55 -> x7 unchanged, no bypass, debug_wb_have_inst=0.
//   5. Both ports read x9 while x9 written 0xA5A5_A5A5 -> rD1=rD2=0xA5A5_A5A5 same cycle.
//   6. Preload via writes, assert cpu_rst_n=0 for 1 cycle concurrent with write x3=0x77
//      -> x3 reads 0 afterwards, wr_count=0; force wr_count to 0xFFFF_FFFF then commit -> 0.

Source files
------------

// File: rtl/wb_regfile.sv
// Write-back register file: two combinational read ports with write-through bypass,
// a one-cycle-delayed commit record for the trace comparator, and a retired-write counter.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst_n,
  input  logic              rf_we,
  input  logic [ADDR_W-1:0] rf_wR,
  input  logic [DATA_W-1:0] rf_wD,
  input  logic [DATA_W-1:0] wb_pc,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] rf_rR1,
  input  logic [ADDR_W-1:0] rf_rR2,
  output logic [DATA_W-1:0] rf_rD1,
  output logic [DATA_W-1:0] rf_rD2,
  output logic              debug_wb_have_inst,
  output logic [DATA_W-1:0] debug_wb_pc,
  output logic              debug_wb_ena,
  output logic [ADDR_W-1:0] debug_wb_reg,
  output logic [DATA_W-1:0] debug_wb_value,
  output logic [31:0]       wr_count
);

  localparam int NREG = 1 << ADDR_W;

  // Entry 0 is cleared at reset and never written, so it reads as zero anyway.
  logic [DATA_W-1:0] regs [0:NREG-1];
  logic              commit;
  logic              wr_nonzero;

  assign wr_nonzero = (rf_wR != '0);
  assign commit     = cpu_rst_n && rf_we && wb_valid && wr_nonzero;

  always_comb begin
    rf_rD1 = '0;
    if (rf_rR1 != '0) begin
      if (commit && (rf_rR1 == rf_wR)) rf_rD1 = rf_wD;
      else                             rf_rD1 = regs[rf_rR1];
    end
  end

  always_comb begin
    rf_rD2 = '0;
    if (rf_rR2 != '0) begin
      if (commit && (rf_rR2 == rf_wR)) rf_rD2 = rf_wD;
      else                             rf_rD2 = regs[rf_rR2];
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      wr_count <= '0;
    end else if (commit) begin
      regs[rf_wR] <= rf_wD;
      wr_count    <= wr_count + 32'd1;
    end
  end

  // Trace record mirrors the sampled inputs even when nothing was written.
  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst_n) begin
      debug_wb_have_inst <= 1'b0;
      debug_wb_pc        <= '0;
      debug_wb_ena       <= 1'b0;
      debug_wb_reg       <= '0;
      debug_wb_value     <= '0;
    end else begin
      debug_wb_have_inst <= wb_valid;
      debug_wb_pc        <= wb_pc;
      debug_wb_ena       <= wb_valid && rf_we && wr_nonzero;
      debug_wb_reg       <= rf_wR;
      debug_wb_value     <= rf_wD;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile: one task per scenario, inline compares.
module tb_wb_regfile;

  logic        cpu_clk;
  logic        cpu_rst_n;
  logic        rf_we;
  logic [4:0]  rf_wR;
  logic [31:0] rf_wD;
  logic [31:0] wb_pc;
  logic        wb_valid;
  logic [4:0]  rf_rR1;
  logic [4:0]  rf_rR2;
  logic [31:0] rf_rD1;
  logic [31:0] rf_rD2;
  logic        debug_wb_have_inst;
  logic [31:0] debug_wb_pc;
  logic        debug_wb_ena;
  logic [4:0]  debug_wb_reg;
  logic [31:0] debug_wb_value;
  logic [31:0] wr_count;

  int n_cmp;
  int n_bad;

  wb_regfile #(.DATA_W(32), .ADDR_W(5)) dut (
    .cpu_clk(cpu_clk),
    .cpu_rst_n(cpu_rst_n),
    .rf_we(rf_we),
    .rf_wR(rf_wR),
    .rf_wD(rf_wD),
    .wb_pc(wb_pc),
    .wb_valid(wb_valid),
    .rf_rR1(rf_rR1),
    .rf_rR2(rf_rR2),
    .rf_rD1(rf_rD1),
    .rf_rD2(rf_rD2),
    .debug_wb_have_inst(debug_wb_have_inst),
    .debug_wb_pc(debug_wb_pc),
    .debug_wb_ena(debug_wb_ena),
    .debug_wb_reg(debug_wb_reg),
    .debug_wb_value(debug_wb_value),
    .wr_count(wr_count)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  // Advance past the next rising edge; registered outputs are stable after this.
  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic idle();
    rf_we    = 1'b0;
    wb_valid = 1'b0;
    rf_wR    = 5'd0;
    rf_wD    = 32'd0;
    wb_pc    = 32'd0;
  endtask

  task automatic test_reset();
    cpu_rst_n = 1'b0;
    idle();
    rf_rR1 = 5'd0;
    rf_rR2 = 5'd0;
    tick();
    tick();
    cpu_rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      rf_rR1 = 5'(i);
      rf_rR2 = 5'(31 - i);
      #1;
      n_cmp++;
      if (rf_rD1 !== 32'd0 || rf_rD2 !== 32'd0) begin
        n_bad++;
        $display("FAIL reset_read idx=%0d got rD1=%h rD2=%h want 0", i, rf_rD1, rf_rD2);
      end
    end
    n_cmp++;
    if (wr_count !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_wr_count got %h want 0", wr_count);
    end
    n_cmp++;
    if ({debug_wb_have_inst, debug_wb_pc, debug_wb_ena, debug_wb_reg, debug_wb_value} !== '0) begin
      n_bad++;
      $display("FAIL reset_debug got have=%b pc=%h ena=%b reg=%0d val=%h want all 0",
               debug_wb_have_inst, debug_wb_pc, debug_wb_ena, debug_wb_reg, debug_wb_value);
    end
  endtask

  task automatic test_write_bypass();
    rf_we = 1'b1; wb_valid = 1'b1; rf_wR = 5'd5; rf_wD = 32'hDEAD_BEEF; wb_pc = 32'h0000_0100;
    rf_rR1 = 5'd5; rf_rR2 = 5'd6;
    #1;
    n_cmp++;
    if (rf_rD1 !== 32'hDEAD_BEEF) begin
      n_bad++;
      $display("FAIL bypass_rd1 got %h want deadbeef", rf_rD1);
    end
    n_cmp++;
    if (rf_rD2 !== 32'd0) begin
      n_bad++;
      $display("FAIL bypass_other_port got %h want 0", rf_rD2);
    end
    tick();
    n_cmp++;
    if (debug_wb_have_inst !== 1'b1 || debug_wb_ena !== 1'b1 || debug_wb_reg !== 5'd5 ||
        debug_wb_value !== 32'hDEAD_BEEF || debug_wb_pc !== 32'h0000_0100) begin
      n_bad++;
      $display("FAIL write_debug got have=%b ena=%b reg=%0d val=%h pc=%h want 1 1 5 deadbeef 00000100",
               debug_wb_have_inst, debug_wb_ena, debug_wb_reg, debug_wb_value, debug_wb_pc);
    end
    idle();
    #1;
    n_cmp++;
    if (rf_rD1 !== 32'hDEAD_BEEF) begin
      n_bad++;
      $display("FAIL write_stored got %h want deadbeef", rf_rD1);
    end
    n_cmp++;
    if (wr_count !== 32'd1) begin
      n_bad++;
      $display("FAIL write_count got %0d want 1", wr_count);
    end
  endtask

  task automatic test_write_x0();
    rf_we = 1'b1; wb_valid = 1'b1; rf_wR = 5'd0; rf_wD = 32'h0000_1234; wb_pc = 32'h0000_0104;
    rf_rR1 = 5'd0; rf_rR2 = 5'd5;
    #1;
    n_cmp++;
    if (rf_rD1 !== 32'd0) begin
      n_bad++;
      $display("FAIL x0_same_cycle got %h want 0", rf_rD1);
    end
    tick();
    n_cmp++;
    if (debug_wb_ena !== 1'b0 || debug_wb_have_inst !== 1'b1) begin
      n_bad++;
      $display("FAIL x0_debug got ena=%b have=%b want 0 1", debug_wb_ena, debug_wb_have_inst);
    end
    idle();
    #1;
    n_cmp++;
    if (rf_rD1 !== 32'd0 || rf_rD2 !== 32'hDEAD_BEEF) begin
      n_bad++;
      $display("FAIL x0_next_cycle got rD1=%h rD2=%h want 0 deadbeef", rf_rD1, rf_rD2);
    end
    n_cmp++;
    if (wr_count !== 32'd1) begin
      n_bad++;
      $display("FAIL x0_count got %0d want 1", wr_count);
    end
  endtask

  task automatic test_bubble();
    rf_we = 1'b1; wb_valid = 1'b0; rf_wR = 5'd7; rf_wD = 32'h0000_0055; wb_pc = 32'h0000_0108;
    rf_rR1 = 5'd7; rf_rR2 = 5'd7;
    #1;
    n_cmp++;
    if (rf_rD1 !== 32'd0 || rf_rD2 !== 32'd0) begin
      n_bad++;
      $display("FAIL bubble_no_bypass got rD1=%h rD2=%h want 0", rf_rD1, rf_rD2);
    end
    tick();
    n_cmp++;
    if (debug_wb_have_inst !== 1'b0 || debug_wb_ena !== 1'b0) begin
      n_bad++;
      $display("FAIL bubble_debug got have=%b ena=%b want 0 0", debug_wb_have_inst, debug_wb_ena);
    end
    idle();
    #1;
    n_cmp++;
    if (rf_rD1 !== 32'd0 || wr_count !== 32'd1) begin
      n_bad++;
      $display("FAIL bubble_state got x7=%h count=%0d want 0 1", rf_rD1, wr_count);
    end
  endtask

  task automatic test_dual_read();
    rf_we = 1'b1; wb_valid = 1'b1; rf_wR = 5'd9; rf_wD = 32'hA5A5_A5A5; wb_pc = 32'h0000_010C;
    rf_rR1 = 5'd9; rf_rR2 = 5'd9;
    #1;
    n_cmp++;
    if (rf_rD1 !== 32'hA5A5_A5A5 || rf_rD2 !== 32'hA5A5_A5A5) begin
      n_bad++;
      $display("FAIL dual_bypass got rD1=%h rD2=%h want a5a5a5a5", rf_rD1, rf_rD2);
    end
    tick();
    idle();
    #1;
    n_cmp++;
    if (rf_rD1 !== 32'hA5A5_A5A5 || rf_rD2 !== 32'hA5A5_A5A5 || wr_count !== 32'd2) begin
      n_bad++;
      $display("FAIL dual_stored got rD1=%h rD2=%h count=%0d want a5a5a5a5 a5a5a5a5 2",
               rf_rD1, rf_rD2, wr_count);
    end
  endtask

  task automatic test_reset_midrun();
    rf_we = 1'b1; wb_valid = 1'b1; rf_wR = 5'd3; rf_wD = 32'h0000_0011; wb_pc = 32'h0000_0110;
    tick();
    n_cmp++;
    if (wr_count !== 32'd3) begin
      n_bad++;
      $display("FAIL preload_count got %0d want 3", wr_count);
    end
    cpu_rst_n = 1'b0;
    rf_wD = 32'h0000_0077; rf_rR1 = 5'd3; rf_rR2 = 5'd9;
    #1;
    n_cmp++;
    if (rf_rD1 !== 32'h0000_0011) begin
      n_bad++;
      $display("FAIL rst_cycle_no_bypass got %h want 00000011", rf_rD1);
    end
    tick();
    cpu_rst_n = 1'b1;
    idle();
    #1;
    n_cmp++;
    if (rf_rD1 !== 32'd0 || rf_rD2 !== 32'd0 || wr_count !== 32'd0) begin
      n_bad++;
      $display("FAIL midrun_reset got x3=%h x9=%h count=%0d want 0 0 0", rf_rD1, rf_rD2, wr_count);
    end
    n_cmp++;
    if (debug_wb_have_inst !== 1'b0 || debug_wb_ena !== 1'b0 || debug_wb_value !== 32'd0) begin
      n_bad++;
      $display("FAIL midrun_debug got have=%b ena=%b val=%h want 0 0 0",
               debug_wb_have_inst, debug_wb_ena, debug_wb_value);
    end
    rf_rR1 = 5'd5;
    #1;
    n_cmp++;
    if (rf_rD1 !== 32'd0) begin
      n_bad++;
      $display("FAIL midrun_x5_cleared got %h want 0", rf_rD1);
    end
    rf_we = 1'b1; wb_valid = 1'b1; rf_wR = 5'd4; rf_wD = 32'h0000_0099; rf_rR1 = 5'd4;
    #1;
    n_cmp++;
    if (rf_rD1 !== 32'h0000_0099) begin
      n_bad++;
      $display("FAIL post_reset_bypass got %h want 00000099", rf_rD1);
    end
    tick();
    idle();
    #1;
    n_cmp++;
    if (wr_count !== 32'd1) begin
      n_bad++;
      $display("FAIL post_reset_count got %0d want 1", wr_count);
    end
  endtask

  task automatic test_wrap();
    force dut.wr_count = 32'hFFFF_FFFF;
    #1;
    release dut.wr_count;
    #1;
    n_cmp++;
    if (wr_count !== 32'hFFFF_FFFF) begin
      n_bad++;
      $display("FAIL wrap_preset got %h want ffffffff", wr_count);
    end
    rf_we = 1'b1; wb_valid = 1'b1; rf_wR = 5'd1; rf_wD = 32'h0000_0042; rf_rR1 = 5'd1;
    tick();
    idle();
    #1;
    n_cmp++;
    if (wr_count !== 32'd0) begin
      n_bad++;
      $display("FAIL wrap_to_zero got %h want 0", wr_count);
    end
    n_cmp++;
    if (rf_rD1 !== 32'h0000_0042) begin
      n_bad++;
      $display("FAIL wrap_write got %h want 00000042", rf_rD1);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_write_bypass();
    test_write_x0();
    test_bubble();
    test_dual_read();
    test_reset_midrun();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
